mat_switch: RTL and testbench

//  Inter-core vector switch sitting downstream of every MatCore's switch send port and upstream of every recv port.

---
 rtl/mat_switch_if.sv | 33 +++
 rtl/mat_switch.sv | 84 ++++++++
 tb/tb_mat_switch.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/mat_switch_if.sv
// Port bundle between the attached MatCores and mat_switch.
// Vectors are carried as raw IEEE-754 single-precision bit patterns.
interface mat_switch_if #(
    parameter int SWITCH_WIDTH          = 16,
    parameter int SWITCH_CORE_SIZE      = 4,
    parameter int SWITCH_CORE_ADDR_SIZE = (SWITCH_CORE_SIZE > 1) ? $clog2(SWITCH_CORE_SIZE) : 1
);
    localparam int N = SWITCH_CORE_SIZE;
    localparam int W = SWITCH_WIDTH;
    localparam int A = SWITCH_CORE_ADDR_SIZE;

    logic [N-1:0]                send_ready;
    logic [N-1:0][A-1:0]         send_core_idx;
    logic [N-1:0][W-1:0][31:0]   send_data;
    logic [N-1:0]                send_ok;

    logic [N-1:0]                recv_request;
    logic [N-1:0][A-1:0]         recv_core_idx;
    logic [N-1:0]                recv_ready;
    logic [N-1:0][W-1:0][31:0]   recv_data;

    modport master (
        output send_ready, send_core_idx, send_data,
        output recv_request, recv_core_idx,
        input  send_ok, recv_ready, recv_data
    );

    modport slave (
        input  send_ready, send_core_idx, send_data,
        input  recv_request, recv_core_idx,
        output send_ok, recv_ready, recv_data
    );
endinterface

// File: rtl/mat_switch.sv
// Inter-core vector switch: one single-entry mailbox per (source, destination) pair.
// Senders fill slot[src][dst], receivers drain slot[src][self]; every pair is independent.
module mat_switch #(
    parameter int SWITCH_WIDTH          = 16,
    parameter int SWITCH_CORE_SIZE      = 4,
    parameter int SWITCH_CORE_ADDR_SIZE = (SWITCH_CORE_SIZE > 1) ? $clog2(SWITCH_CORE_SIZE) : 1
) (
    input  logic          clock,
    input  logic          reset,
    mat_switch_if.slave   sw
);
    localparam int N = SWITCH_CORE_SIZE;
    localparam int W = SWITCH_WIDTH;
    localparam int A = SWITCH_CORE_ADDR_SIZE;

    typedef logic [W-1:0][31:0] vec_t;

    vec_t                slot_data [N][N];
    logic [N-1:0][N-1:0] slot_full;
    logic [N-1:0][N-1:0] full_next;
    logic [N-1:0]        send_accept;
    logic [N-1:0]        recv_accept;

    // Indices beyond the attached core count never address a slot.
    function automatic logic idx_valid(input logic [A-1:0] idx);
        return int'(idx) < N;
    endfunction

    // Both sides see the pre-edge slot_full, so a send and a recv can never
    // both act on the same slot in one cycle.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        send_accept = '0;
        recv_accept = '0;
        full_next   = slot_full;

        for (int s = 0; s < N; s++) begin
            if (sw.send_ready[s] && !sw.send_ok[s] && idx_valid(sw.send_core_idx[s]))
                send_accept[s] = !slot_full[s][sw.send_core_idx[s]];
        end

        for (int r = 0; r < N; r++) begin
            if (sw.recv_request[r] && !sw.recv_ready[r] && idx_valid(sw.recv_core_idx[r]))
                recv_accept[r] = slot_full[sw.recv_core_idx[r]][r];
        end

        for (int r = 0; r < N; r++) begin
            if (recv_accept[r])
                full_next[sw.recv_core_idx[r]][r] = 1'b0;
        end

        for (int s = 0; s < N; s++) begin
            if (send_accept[s])
                full_next[s][sw.send_core_idx[s]] = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clock) begin
        if (!reset) begin
            slot_full     <= '0;
            sw.send_ok    <= '0;
            sw.recv_ready <= '0;
            sw.recv_data  <= '0;
        end else begin
            slot_full     <= full_next;
            sw.send_ok    <= send_accept;
            sw.recv_ready <= recv_accept;
            for (int r = 0; r < N; r++) begin
                if (recv_accept[r])
                    sw.recv_data[r] <= slot_data[sw.recv_core_idx[r]][r];
            end
        end
    end

    // NOTE: the mailbox storage is deliberately not reset; slot_full alone decides whether contents are valid.
    always_ff @(posedge clock) begin
        for (int s = 0; s < N; s++) begin
            if (send_accept[s])
                slot_data[s][sw.send_core_idx[s]] <= sw.send_data[s];
        end
    end

endmodule

// File: tb/tb_mat_switch.sv
// Directed bench for mat_switch: reset, latency, stall/drain ordering, same-slot
// collisions (full and empty), all-core exchange, self-send and mid-flight reset.
module tb_mat_switch;
    localparam int N = 4;
    localparam int W = 16;

    typedef logic [W-1:0][31:0] vec_t;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   n_total = 0;
    int   n_pass  = 0;

    always #5 clock = ~clock;

    mat_switch_if #(.SWITCH_WIDTH(W), .SWITCH_CORE_SIZE(N)) sw ();

    mat_switch #(.SWITCH_WIDTH(W), .SWITCH_CORE_SIZE(N)) dut (
        .clock (clock),
        .reset (reset),
        .sw    (sw)
    );

    // IEEE-754 single-precision encoding of a small positive integer (1..255).
    function automatic logic [31:0] fp_bits(input int n);
        int          e;
        logic [31:0] m;
        e = 0;
        while ((n >> (e + 1)) != 0) e++;
        m = 32'(n) << (23 - e);
        return {1'b0, 8'(127 + e), m[22:0]};
    endfunction

    // Vector of consecutive integers base, base+1, ... as shortreal bit patterns.
    function automatic vec_t make_vec(input int base);
        vec_t v;
        for (int j = 0; j < W; j++) v[j] = fp_bits(base + j);
        return v;
    endfunction

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Advance one cycle; outputs are observed 1 ns after the edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send(input int s, input int d, input vec_t v);
        sw.send_ready[s]    = 1'b1;
        sw.send_core_idx[s] = 2'(d);
        sw.send_data[s]     = v;
    endtask

    task automatic recv(input int r, input int s);
        sw.recv_request[r]  = 1'b1;
        sw.recv_core_idx[r] = 2'(s);
    endtask

    vec_t va, vb, vc, vd, vs, ve;

    initial begin
        sw.send_ready    = '0;
        sw.send_core_idx = '0;
        sw.send_data     = '0;
        sw.recv_request  = '0;
        sw.recv_core_idx = '0;

        // Reset held low for two cycles.
        tick();
        tick();
        check("rst_send_ok", 512'(sw.send_ok), 512'(0));
        check("rst_recv_ready", 512'(sw.recv_ready), 512'(0));
        for (int r = 0; r < N; r++) check($sformatf("rst_recv_data%0d", r), sw.recv_data[r], '0);

        // After release, every core asks every empty slot: nobody is answered.
        reset = 1'b1;
        for (int r = 0; r < N; r++) recv(r, r);
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("empty_recv_%0d", k), 512'(sw.recv_ready), 512'(0));
        end
        sw.recv_request = '0;
        tick();

        // Core0 -> core2, earliest possible recv (request the cycle send_ok is seen).
        va = make_vec(1);
        send(0, 2, va);
        tick();
        check("t2_send_ok", 512'(sw.send_ok), 512'(4'b0001));
        check("t2_recv_early", 512'(sw.recv_ready), 512'(0));
        sw.send_ready[0] = 1'b0;
        recv(2, 0);
        tick();
        check("t2_recv_ready", 512'(sw.recv_ready), 512'(4'b0100));
        check("t2_recv_data", sw.recv_data[2], va);
        check("t2_elem0_1p0", 512'(sw.recv_data[2][0]), 512'(32'h3F80_0000));
        check("t2_elem15_16p0", 512'(sw.recv_data[2][15]), 512'(32'h4180_0000));
        check("t2_send_ok_pulse", 512'(sw.send_ok), 512'(0));
        sw.recv_request[2] = 1'b0;
        tick();
        check("t2_recv_pulse", 512'(sw.recv_ready), 512'(0));
        check("t2_data_hold", sw.recv_data[2], va);

        // Core1 sends A then B to core3; B stalls until core3 drains A.
        va = make_vec(17);
        vb = make_vec(33);
        send(1, 3, va);
        tick();
        check("t3_a_ok", 512'(sw.send_ok), 512'(4'b0010));
        sw.send_data[1] = vb;
        tick();
        check("t3_b_cooldown", 512'(sw.send_ok), 512'(0));
        tick();
        check("t3_b_stalled", 512'(sw.send_ok), 512'(0));
        recv(3, 1);
        tick();
        check("t3_recv_a_ready", 512'(sw.recv_ready), 512'(4'b1000));
        check("t3_recv_a_data", sw.recv_data[3], va);
        check("t3_b_rejected_on_drain", 512'(sw.send_ok), 512'(0));
        sw.recv_request[3] = 1'b0;
        tick();
        check("t3_b_ok", 512'(sw.send_ok), 512'(4'b0010));
        sw.send_ready[1] = 1'b0;
        recv(3, 1);
        tick();
        check("t3_recv_b_ready", 512'(sw.recv_ready), 512'(4'b1000));
        check("t3_recv_b_data", sw.recv_data[3], vb);
        sw.recv_request[3] = 1'b0;
        tick();

        // Full slot, same-cycle send and recv: recv gets old data, send accepted one cycle later.
        vc = make_vec(50);
        vd = make_vec(70);
        send(2, 0, vc);
        tick();
        check("t4_c_ok", 512'(sw.send_ok), 512'(4'b0100));
        sw.send_ready[2] = 1'b0;
        tick();
        send(2, 0, vd);
        recv(0, 2);
        tick();
        check("t4_recv_old_ready", 512'(sw.recv_ready), 512'(4'b0001));
        check("t4_recv_old_data", sw.recv_data[0], vc);
        check("t4_send_rejected", 512'(sw.send_ok), 512'(0));
        sw.recv_request[0] = 1'b0;
        tick();
        check("t4_send_late_ok", 512'(sw.send_ok), 512'(4'b0100));
        sw.send_ready[2] = 1'b0;
        recv(0, 2);
        tick();
        check("t4_recv_new_data", sw.recv_data[0], vd);
        sw.recv_request[0] = 1'b0;

        // Empty slot, same-cycle send and recv: send fills, recv served next cycle.
        ve = make_vec(90);
        send(0, 1, ve);
        recv(1, 0);
        tick();
        check("t4e_send_ok", 512'(sw.send_ok), 512'(4'b0001));
        check("t4e_recv_not_served", 512'(sw.recv_ready), 512'(0));
        sw.send_ready[0] = 1'b0;
        tick();
        check("t4e_recv_ready", 512'(sw.recv_ready), 512'(4'b0010));
        check("t4e_recv_data", sw.recv_data[1], ve);
        sw.recv_request[1] = 1'b0;
        tick();

        // Self-send uses slot[3][3].
        vs = make_vec(200);
        send(3, 3, vs);
        tick();
        check("self_send_ok", 512'(sw.send_ok), 512'(4'b1000));
        sw.send_ready[3] = 1'b0;
        recv(3, 3);
        tick();
        check("self_recv_ready", 512'(sw.recv_ready), 512'(4'b1000));
        check("self_recv_data", sw.recv_data[3], vs);
        sw.recv_request[3] = 1'b0;
        tick();

        // Ring exchange: every core sends to its right neighbour in the same cycle.
        for (int i = 0; i < N; i++) send(i, (i + 1) % N, make_vec(20 * (i + 1)));
        tick();
        check("ring_send_ok", 512'(sw.send_ok), 512'(4'b1111));
        sw.send_ready = '0;
        for (int r = 0; r < N; r++) recv(r, (r + N - 1) % N);
        tick();
        check("ring_recv_ready", 512'(sw.recv_ready), 512'(4'b1111));
        for (int r = 0; r < N; r++)
            check($sformatf("ring_recv_data%0d", r), sw.recv_data[r], make_vec(20 * (((r + N - 1) % N) + 1)));
        sw.recv_request = '0;
        tick();

        // Reset between accept and recv drops the vector.
        send(0, 1, make_vec(7));
        tick();
        check("t6_send_ok", 512'(sw.send_ok), 512'(4'b0001));
        sw.send_ready[0] = 1'b0;
        reset = 1'b0;
        tick();
        check("t6_rst_send_ok", 512'(sw.send_ok), 512'(0));
        check("t6_rst_recv_ready", 512'(sw.recv_ready), 512'(0));
        check("t6_rst_recv_data0", sw.recv_data[0], '0);
        reset = 1'b1;
        recv(1, 0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("t6_recv_dropped_%0d", k), 512'(sw.recv_ready), 512'(0));
        end
        check("t6_recv_data1_cleared", sw.recv_data[1], '0);
        sw.recv_request = '0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
